// File: rtl/axi_r_resp_allocator.sv
// AXI read-response allocator: round-robin source select, burst lock until RLAST.
// Pure flow-through mux; only the arbitration state is registered.
module axi_r_resp_allocator #(
    parameter int N_INIT_PORT = 8,
    parameter int AXI_DATA_W  = 64,
    parameter int AXI_ID_W    = 16 + $clog2(N_INIT_PORT),
    parameter int AXI_USER_W  = 6
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_INIT_PORT*AXI_ID_W-1:0]   rid_i,
    input  logic [N_INIT_PORT*AXI_DATA_W-1:0] rdata_i,
    input  logic [N_INIT_PORT*2-1:0]          rresp_i,
    input  logic [N_INIT_PORT-1:0]            rlast_i,
    input  logic [N_INIT_PORT*AXI_USER_W-1:0] ruser_i,
    input  logic [N_INIT_PORT-1:0]            rvalid_i,
    output logic [N_INIT_PORT-1:0]            rready_o,
    output logic [AXI_ID_W-1:0]               rid_o,
    output logic [AXI_DATA_W-1:0]             rdata_o,
    output logic [1:0]                        rresp_o,
    output logic                              rlast_o,
    output logic [AXI_USER_W-1:0]             ruser_o,
    output logic                              rvalid_o,
    input  logic                              rready_i
);

    localparam int IDX_W = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [IDX_W:0]   cnt_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t lock_q;
    idx_t   prio_q;
    idx_t   owner_q;

    idx_t   grant_idx;
    logic   grant_vld;
    cnt_t   cand;
    logic [N_INIT_PORT-1:0] sel;
    idx_t   prio_nxt;
    logic   hs;

    // Pick the granted source: the locked owner, else first requester from prio_q.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (lock_q == LOCKED) begin
            grant_vld = 1'b1;
            grant_idx = owner_q;
        end else begin
            for (int i = 0; i < N_INIT_PORT; i++) begin
                cand = {1'b0, prio_q} + cnt_t'(i);
                if (cand >= cnt_t'(N_INIT_PORT)) begin
                    cand = cand - cnt_t'(N_INIT_PORT);
                end
                if (!grant_vld && rvalid_i[cand[IDX_W-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand[IDX_W-1:0];
                end
            end
        end
    end

    // One-hot select of the granted source; empty when nothing is granted.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N_INIT_PORT; i++) begin
            sel[i] = grant_vld && (grant_idx == idx_t'(i));
        end
    end

    // AND-OR mux of the selected source onto the initiator R channel.
    always_comb begin
        rid_o    = '0;
        rdata_o  = '0;
        rresp_o  = '0;
        rlast_o  = 1'b0;
        ruser_o  = '0;
        rvalid_o = 1'b0;
        for (int i = 0; i < N_INIT_PORT; i++) begin
            rid_o   |= rid_i[i*AXI_ID_W +: AXI_ID_W]
                       & {AXI_ID_W{sel[i]}};
            rdata_o |= rdata_i[i*AXI_DATA_W +: AXI_DATA_W]
                       & {AXI_DATA_W{sel[i]}};
            rresp_o |= rresp_i[i*2 +: 2] & {2{sel[i]}};
            ruser_o |= ruser_i[i*AXI_USER_W +: AXI_USER_W]
                       & {AXI_USER_W{sel[i]}};
            rlast_o  |= rlast_i[i] & sel[i];
            rvalid_o |= rvalid_i[i] & sel[i];
        end
    end

    // Ready is steered back only to the granted source.
    always_comb begin
        rready_o = sel & {N_INIT_PORT{rready_i}};
    end

    // Handshake and the pointer value following the current grant.
    always_comb begin
        hs = rvalid_o & rready_i;
        if (grant_idx == idx_t'(N_INIT_PORT - 1)) begin
            prio_nxt = '0;
        end else begin
            prio_nxt = grant_idx + idx_t'(1);
        end
    end

    // Lock on any unfinished or stalled beat; release and advance on the RLAST handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q  <= IDLE;
            prio_q  <= '0;
            owner_q <= '0;
        end else begin
            if (hs && rlast_o) begin
                lock_q <= IDLE;
                prio_q <= prio_nxt;
            end else if ((lock_q == IDLE) && rvalid_o) begin
                lock_q  <= LOCKED;
                owner_q <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_axi_r_resp_allocator.sv
// Directed bench for axi_r_resp_allocator with four response sources.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_axi_r_resp_allocator;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int IW = 16 + $clog2(N);
    localparam int UW = 6;

    logic              clk;
    logic              rst_n;
    logic [N*IW-1:0]   rid_i;
    logic [N*DW-1:0]   rdata_i;
    logic [N*2-1:0]    rresp_i;
    logic [N-1:0]      rlast_i;
    logic [N*UW-1:0]   ruser_i;
    logic [N-1:0]      rvalid_i;
    logic [N-1:0]      rready_o;
    logic [IW-1:0]     rid_o;
    logic [DW-1:0]     rdata_o;
    logic [1:0]        rresp_o;
    logic              rlast_o;
    logic [UW-1:0]     ruser_o;
    logic              rvalid_o;
    logic              rready_i;

    logic              vld_a [N];
    logic              lst_a [N];
    logic [31:0]       beat_a [N];

    int checks = 0;
    int errors = 0;

    axi_r_resp_allocator #(
        .N_INIT_PORT (N),
        .AXI_DATA_W  (DW),
        .AXI_ID_W    (IW),
        .AXI_USER_W  (UW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rid_i    (rid_i),
        .rdata_i  (rdata_i),
        .rresp_i  (rresp_i),
        .rlast_i  (rlast_i),
        .ruser_i  (ruser_i),
        .rvalid_i (rvalid_i),
        .rready_o (rready_o),
        .rid_o    (rid_o),
        .rdata_o  (rdata_o),
        .rresp_o  (rresp_o),
        .rlast_o  (rlast_o),
        .ruser_o  (ruser_o),
        .rvalid_o (rvalid_o),
        .rready_i (rready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rid_i    = '0;
        rdata_i  = '0;
        rresp_i  = '0;
        rlast_i  = '0;
        ruser_i  = '0;
        rvalid_i = '0;
        for (int k = 0; k < N; k++) begin
            rid_i[k*IW +: IW]   = IW'(32'h1000 + k);
            rdata_i[k*DW +: DW] = {32'hDA7A_0000 | 32'(k), beat_a[k]};
            rresp_i[k*2 +: 2]   = 2'(k);
            ruser_i[k*UW +: UW] = UW'(6'h10 + k);
            rlast_i[k]          = lst_a[k];
            rvalid_i[k]         = vld_a[k];
        end
    end

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int k = 0; k < N; k++) begin
            vld_a[k]  = 1'b0;
            lst_a[k]  = 1'b0;
            beat_a[k] = '0;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        rready_i = 1'b0;
        clr();
        #1;

        // reset / idle
        chk("rst_rvalid", 64'(rvalid_o), 64'h0);
        chk("rst_rready", 64'(rready_o), 64'h0);
        chk("rst_rid", 64'(rid_o), 64'h0);
        chk("rst_rdata", rdata_o, 64'h0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // round robin with single-beat bursts
        rready_i = 1'b1;
        for (int k = 0; k < N; k++) begin
            vld_a[k] = 1'b1;
            lst_a[k] = 1'b1;
        end
        #1;
        chk("rr0_rready", 64'(rready_o), 64'h1);
        chk("rr0_rid", 64'(rid_o), 64'h1000);
        cyc();
        #1;
        chk("rr1_rready", 64'(rready_o), 64'h2);
        chk("rr1_rid", 64'(rid_o), 64'h1001);
        chk("rr1_ruser", 64'(ruser_o), 64'h11);
        cyc();
        #1;
        chk("rr2_rready", 64'(rready_o), 64'h4);
        chk("rr2_rresp", 64'(rresp_o), 64'h2);
        cyc();
        #1;
        chk("rr3_rready", 64'(rready_o), 64'h8);
        chk("rr3_rid", 64'(rid_o), 64'h1003);
        cyc();
        #1;
        chk("rr4_rready", 64'(rready_o), 64'h1);
        cyc();
        clr();

        // burst lock: source 2 four beats, source 1 waits (pointer at 1)
        vld_a[2]  = 1'b1;
        beat_a[2] = 32'd1;
        #1;
        chk("lk_b1_rready", 64'(rready_o), 64'h4);
        cyc();
        vld_a[1]  = 1'b1;
        lst_a[1]  = 1'b1;
        beat_a[2] = 32'd2;
        #1;
        chk("lk_b2_rready", 64'(rready_o), 64'h4);
        chk("lk_b2_rdata", rdata_o, 64'hDA7A_0002_0000_0002);
        cyc();
        beat_a[2] = 32'd3;
        #1;
        chk("lk_b3_rready", 64'(rready_o), 64'h4);
        cyc();
        beat_a[2] = 32'd4;
        lst_a[2]  = 1'b1;
        #1;
        chk("lk_b4_rready", 64'(rready_o), 64'h4);
        chk("lk_b4_rlast", 64'(rlast_o), 64'h1);
        cyc();
        vld_a[2] = 1'b0;
        #1;
        chk("lk_next_rready", 64'(rready_o), 64'h2);
        chk("lk_next_rid", 64'(rid_o), 64'h1001);
        chk("lk_next_rdata", rdata_o, 64'hDA7A_0001_0000_0000);
        cyc();
        clr();

        // single beat from source 3 moves the pointer to 0
        vld_a[3] = 1'b1;
        lst_a[3] = 1'b1;
        #1;
        chk("pre_st_rready", 64'(rready_o), 64'h8);
        cyc();

        // stall hold: sources 0 and 3 valid, rready_i low for 5 cycles
        vld_a[0]  = 1'b1;
        lst_a[0]  = 1'b1;
        beat_a[0] = 32'h55;
        rready_i  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("st_rvalid", 64'(rvalid_o), 64'h1);
            chk("st_rid", 64'(rid_o), 64'h1000);
            chk("st_rdata", rdata_o, 64'hDA7A_0000_0000_0055);
            chk("st_rready", 64'(rready_o), 64'h0);
            cyc();
        end
        rready_i = 1'b1;
        #1;
        chk("st_rel_rready", 64'(rready_o), 64'h1);
        cyc();
        vld_a[0] = 1'b0;
        #1;
        chk("st_s3_rready", 64'(rready_o), 64'h8);
        cyc();
        clr();

        // single beat from source 2 moves the pointer to 3
        vld_a[2] = 1'b1;
        lst_a[2] = 1'b1;
        #1;
        chk("pre_wr_rready", 64'(rready_o), 64'h4);
        cyc();
        clr();

        // wrap-around: requests 1001 with pointer 3
        vld_a[3] = 1'b1;
        vld_a[0] = 1'b1;
        lst_a[0] = 1'b1;
        #1;
        chk("wr_b1_rready", 64'(rready_o), 64'h8);
        chk("wr_b1_rlast", 64'(rlast_o), 64'h0);
        cyc();
        lst_a[3] = 1'b1;
        #1;
        chk("wr_b2_rready", 64'(rready_o), 64'h8);
        cyc();
        vld_a[3] = 1'b0;
        #1;
        chk("wr_s0_rready", 64'(rready_o), 64'h1);
        chk("wr_s0_rid", 64'(rid_o), 64'h1000);
        cyc();
        clr();

        // valid gap inside a source-1 burst (pointer at 1)
        vld_a[1] = 1'b1;
        vld_a[0] = 1'b1;
        lst_a[0] = 1'b1;
        vld_a[2] = 1'b1;
        lst_a[2] = 1'b1;
        #1;
        chk("gp_b1_rready", 64'(rready_o), 64'h2);
        chk("gp_b1_rvalid", 64'(rvalid_o), 64'h1);
        cyc();
        #1;
        chk("gp_b2_rready", 64'(rready_o), 64'h2);
        cyc();
        vld_a[1] = 1'b0;
        #1;
        chk("gp_g1_rvalid", 64'(rvalid_o), 64'h0);
        chk("gp_g1_rready", 64'(rready_o), 64'h2);
        cyc();
        #1;
        chk("gp_g2_rvalid", 64'(rvalid_o), 64'h0);
        chk("gp_g2_rready", 64'(rready_o), 64'h2);
        cyc();
        vld_a[1] = 1'b1;
        #1;
        chk("gp_b3_rready", 64'(rready_o), 64'h2);
        chk("gp_b3_rvalid", 64'(rvalid_o), 64'h1);
        cyc();
        lst_a[1] = 1'b1;
        #1;
        chk("gp_b4_rready", 64'(rready_o), 64'h2);
        chk("gp_b4_rlast", 64'(rlast_o), 64'h1);
        cyc();
        vld_a[1] = 1'b0;
        #1;
        chk("gp_next_rready", 64'(rready_o), 64'h4);
        cyc();
        clr();

        // reset mid-burst: source 1 locked, source 0 requesting (pointer at 3)
        vld_a[1] = 1'b1;
        #1;
        chk("rm_b1_rready", 64'(rready_o), 64'h2);
        cyc();
        vld_a[0] = 1'b1;
        lst_a[0] = 1'b1;
        #1;
        chk("rm_b2_rready", 64'(rready_o), 64'h2);
        rst_n = 1'b0;
        #1;
        chk("rm_rst_rready", 64'(rready_o), 64'h1);
        chk("rm_rst_rid", 64'(rid_o), 64'h1000);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("rm_rel_rready", 64'(rready_o), 64'h1);
        chk("rm_rel_rvalid", 64'(rvalid_o), 64'h1);
        cyc();
        clr();
        #1;
        chk("end_rvalid", 64'(rvalid_o), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_r_resp_allocator.md
# axi_r_resp_allocator

Read-response (R channel) allocator for one initiator-side port of the AXI node. It collects R beats from N_INIT_PORT target-side ports, which are already routed here by the read-response address decoders. It grants one source at a time, round-robin, and holds that grant for a whole burst until the RLAST handshake. Beats are muxed onto a single AXI R output toward the initiator.

## Interface
- N_INIT_PORT, 8: number of response sources; must be ≥2.
- AXI_DATA_W, 64: RDATA width.
- AXI_ID_W, 16+`log2(N_INIT_PORT-1)`: RID width; the ID passes through unchanged.
- AXI_USER_W, 6: RUSER width.
- clk  in  1  clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rid_i  in  N_INIT_PORT*AXI_ID_W  packed per-source RID; source k is at slice [k*AXI_ID_W +: AXI_ID_W].
- rdata_i  in  N_INIT_PORT*AXI_DATA_W  packed RDATA.
- rresp_i  in  N_INIT_PORT*2  packed RRESP.
- rlast_i  in  N_INIT_PORT  per-source RLAST.
- ruser_i  in  N_INIT_PORT*AXI_USER_W  packed RUSER.
- rvalid_i  in  N_INIT_PORT  per-source valid.
- rready_o  out  N_INIT_PORT  per-source ready.
- rid_o, rdata_o, rresp_o, rlast_o, ruser_o  out  AXI_ID_W, AXI_DATA_W, 2, 1, AXI_USER_W  muxed R payload.
- rvalid_o  out  1  output valid.
- rready_i  in  1  initiator ready.

## Operation
- State registers:
  - prio_q, `log2(N_INIT_PORT-1)` bits: round-robin pointer.
  - lock_q, 1 bit: a burst is in progress.
  - owner_q: index of the locked source.
- IDLE (lock_q=0): grant goes to the first k with rvalid_i[k]=1, searching cyclically from prio_q (prio_q, prio_q+1, … mod N_INIT_PORT). No request means no grant.
- LOCKED (lock_q=1): grant = owner_q unconditionally. All other sources see rready_o=0 and are not muxed.
- Outputs:
  - rvalid_o = rvalid_i[grant] when a grant exists, else 0.
  - All payload outputs = slice[grant]. When there is no grant, payload is 0.
  - rready_o[grant] = rready_i; all other rready_o bits = 0.
- Handshake (hs) = rvalid_o & rready_i.
- Transitions:
  - IDLE → LOCKED, owner_q←grant: on hs with rlast_o=0, or on rvalid_o=1 with rready_i=0. A valid beat that is not accepted keeps its source; AXI payload stability requires this.
  - LOCKED → LOCKED: on hs with rlast_o=0, or no hs.
  - Any state → IDLE, prio_q←(grant+1) mod N_INIT_PORT: on hs with rlast_o=1. The pointer wraps from N_INIT_PORT-1 to 0.
  - IDLE, no request: state unchanged.
- Single-beat bursts (rlast=1 on the first beat) with rready_i=1 never enter LOCKED.
- While LOCKED, rvalid_i[owner_q] dropping to 0 is legal. rvalid_o follows it to 0, and the lock is held until RLAST completes.
- No data storage; the block is pure flow-through under registered arbitration state.

## Timing
- Zero-cycle latency: rvalid_i→rvalid_o, payload, and rready_i→rready_o are combinational. State updates on the clk edge after hs.
- Reset (rst_n=0, asynchronous): prio_q=0, lock_q=0, owner_q=0. With rvalid_i=0, all outputs read 0, including rvalid_o and rready_o.
- Reset asserted mid-burst: the lock is dropped immediately. After release, arbitration restarts from source 0.
- Simultaneous requests: exactly one grant. A source that is requesting is granted within N_INIT_PORT-1 bursts.
- Back-to-back: a new burst from any source may be granted in the cycle immediately after the RLAST handshake. There are no bubble cycles.
- No combinational path from rready_i to rvalid_o.

## Test plan
- Reset/idle (N_INIT_PORT=4): assert rst_n=0 mid-simulation with rvalid_i=4'b0000 → rvalid_o=0, rready_o=4'b0000. After release, raise rvalid_i=4'b1111 with single-beat bursts and rready_i=1 → grants follow 0,1,2,3,0 on consecutive cycles.
- Burst lock: source 2 sends 4 beats (rlast on beat 4). Source 1 asserts rvalid from cycle 2 → rready_o[1]=0 until source 2's beat-4 handshake. Source 1 is granted the next cycle, and rid_o equals rid_i slice 1.
- Stall hold: source 3 is valid, rready_i=0 for 5 cycles, and source 0 is also valid with prio_q=0 at start → grant stays 0 all 5 cycles with a stable payload, and source 3 is not granted.
- Wrap-around: prio_q=3, requests 4'b1001 → source 3 is granted first. After its rlast, prio_q=0 and source 0 is granted.
- Valid gap in burst: owner drops rvalid for 2 cycles between beats 2 and 3 while other sources request → rvalid_o=0 during the gap, the lock holds, and the burst completes with 4 beats total.
- Reset mid-burst: rst_n=0 during beat 2 of a source-1 burst → lock_q=0 immediately. After release, source 0 is granted if it requests.
